// File: rtl/ascii_num_pkg.sv
// ascii_num_pkg
//   Shared constants for the ASCII decimal number decoder:
//   - FSM state encoding (IDLE / ACCUM / DISCARD)
//   - err_code values reported on the error strobe
//   - ASCII characters the decoder recognises
//   - character class codes produced by ascii_char_class
package ascii_num_pkg;

    // FSM states
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // err_code values
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_LINE     = 2'd3;

    // ASCII characters
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Character classes
    localparam logic [1:0] CLS_OTHER = 2'd0;
    localparam logic [1:0] CLS_DIGIT = 2'd1;
    localparam logic [1:0] CLS_TERM  = 2'd2;
    localparam logic [1:0] CLS_MINUS = 2'd3;

endpackage

// File: rtl/ascii_char_class.sv
// ascii_char_class
//   Purely combinational byte classifier.
//   Parameters:
//     TERM_CHAR  - byte treated as the line terminator
//   Ports:
//     rx_data    in   8  byte to classify
//     char_class out  2  CLS_DIGIT / CLS_TERM / CLS_MINUS / CLS_OTHER
//     digit_val  out  4  binary value of the digit (meaningful for CLS_DIGIT)
module ascii_char_class
    import ascii_num_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = 8'h0D
) (
    input  logic [7:0] rx_data,
    output logic [1:0] char_class,
    output logic [3:0] digit_val
);

    always_comb begin
        char_class = CLS_OTHER;
        // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value
        digit_val  = rx_data[3:0];
        // The terminator is checked first so a custom TERM_CHAR always wins
        if (rx_data == TERM_CHAR) begin
            char_class = CLS_TERM;
        end else if ((rx_data >= ASCII_0) && (rx_data <= ASCII_9)) begin
            char_class = CLS_DIGIT;
        end else if (rx_data == ASCII_MINUS) begin
            char_class = CLS_MINUS;
        end
    end

endmodule

// File: rtl/ascii_num_decoder.sv
// ascii_num_decoder
//   Accumulates a multi-digit ASCII decimal number from the uart_rx byte
//   stream and emits the binary value on a terminator character.
//   Optional feature macro: ASCII_NUM_SIGN_EN (leading '-' accepted,
//   two's-complement result). Without it '-' is a bad character.
//   Parameters:
//     VALUE_W     - result width
//     MAX_DIGITS  - maximum digits per number
//     TERM_CHAR   - line terminator byte
//   Ports:
//     clk          in   1                       system clock
//     rst_n        in   1                       synchronous active-low reset
//     rx_data      in   8                       received byte
//     rx_valid     in   1                       rx_data strobe
//     rx_err       in   1                       line error strobe (wins over rx_valid)
//     value        out  VALUE_W                 last completed number
//     value_valid  out  1                       one-cycle pulse when value updates
//     err_code     out  2                       0 none, 1 bad char, 2 overflow, 3 line error
//     err_valid    out  1                       one-cycle pulse when err_code updates
//     digit_count  out  $clog2(MAX_DIGITS+1)    digits accepted in the current number
//     busy         out  1                       high in ACCUM or DISCARD
module ascii_num_decoder
    import ascii_num_pkg::*;
#(
    parameter int         VALUE_W    = 16,
    parameter int         MAX_DIGITS = 5,
    parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    input  logic                              rx_err,
    output logic [VALUE_W-1:0]                value,
    output logic                              value_valid,
    output logic [1:0]                        err_code,
    output logic                              err_valid,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                              busy
);

    localparam int ACC_W = VALUE_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

`ifdef ASCII_NUM_SIGN_EN
    localparam logic [ACC_W-1:0] LIM_POS = {5'b00000, {(VALUE_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] LIM_NEG = {4'b0000, 1'b1, {(VALUE_W-1){1'b0}}};

    function automatic logic over_limit(input logic [ACC_W-1:0] a, input logic n);
        over_limit = n ? (a > LIM_NEG) : (a > LIM_POS);
    endfunction

    // Magnitude to two's complement; -2^(VALUE_W-1) maps onto itself
    function automatic logic [VALUE_W-1:0] to_value(input logic [VALUE_W-1:0] mag,
                                                    input logic n);
        logic signed [VALUE_W-1:0] s;
        s = signed'(mag);
        to_value = n ? unsigned'(-s) : unsigned'(s);
    endfunction
`else
    localparam logic [ACC_W-1:0] LIM_U = {4'b0000, {VALUE_W{1'b1}}};

    function automatic logic over_limit(input logic [ACC_W-1:0] a);
        over_limit = (a > LIM_U);
    endfunction
`endif

    logic [1:0]         char_class;
    logic [3:0]         digit_val;
    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic [VALUE_W-1:0] value_p1;
    logic               vld_p1;
    logic [1:0]         err_code_p1;
    logic               err_vld_p1;
`ifdef ASCII_NUM_SIGN_EN
    logic               neg;
`endif

    ascii_char_class #(
        .TERM_CHAR (TERM_CHAR)
    ) u_class (
        .rx_data    (rx_data),
        .char_class (char_class),
        .digit_val  (digit_val)
    );

    // Candidate before commit; ACC_W bits guarantee acc*10+9 cannot wrap
    assign acc_next = acc * ACC_W'(10) + ACC_W'(digit_val);

    // ---- stage p0 -> p1: byte decision and registered outputs ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            value_p1    <= '0;
            vld_p1      <= 1'b0;
            err_code_p1 <= ERR_NONE;
            err_vld_p1  <= 1'b0;
`ifdef ASCII_NUM_SIGN_EN
            neg         <= 1'b0;
`endif
        end else begin
            vld_p1     <= 1'b0;
            err_vld_p1 <= 1'b0;
            if (rx_err) begin
                // Line error drops any coincident byte
                err_code_p1 <= ERR_LINE;
                err_vld_p1  <= 1'b1;
                state       <= ST_DISCARD;
            end else if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        case (char_class)
                            CLS_DIGIT: begin
                                acc   <= ACC_W'(digit_val);
                                cnt   <= CNT_W'(1);
                                state <= ST_ACCUM;
`ifdef ASCII_NUM_SIGN_EN
                                neg   <= 1'b0;
`endif
                            end
                            CLS_TERM: begin
                                // empty line, nothing to report
                            end
`ifdef ASCII_NUM_SIGN_EN
                            CLS_MINUS: begin
                                neg   <= 1'b1;
                                acc   <= '0;
                                cnt   <= '0;
                                state <= ST_ACCUM;
                            end
`endif
                            default: begin
                                err_code_p1 <= ERR_BAD_CHAR;
                                err_vld_p1  <= 1'b1;
                                state       <= ST_DISCARD;
                            end
                        endcase
                    end
                    ST_ACCUM: begin
                        case (char_class)
                            CLS_DIGIT: begin
`ifdef ASCII_NUM_SIGN_EN
                                if ((cnt == CNT_W'(MAX_DIGITS)) || over_limit(acc_next, neg)) begin
`else
                                if ((cnt == CNT_W'(MAX_DIGITS)) || over_limit(acc_next)) begin
`endif
                                    err_code_p1 <= ERR_OVERFLOW;
                                    err_vld_p1  <= 1'b1;
                                    state       <= ST_DISCARD;
                                end else begin
                                    acc <= acc_next;
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end
                            CLS_TERM: begin
                                state <= ST_IDLE;
                                cnt   <= '0;
`ifdef ASCII_NUM_SIGN_EN
                                // A lone '-' is not a number; the terminator still ends the line
                                if (cnt == '0) begin
                                    err_code_p1 <= ERR_BAD_CHAR;
                                    err_vld_p1  <= 1'b1;
                                end else begin
                                    value_p1 <= to_value(acc[VALUE_W-1:0], neg);
                                    vld_p1   <= 1'b1;
                                end
`else
                                value_p1 <= acc[VALUE_W-1:0];
                                vld_p1   <= 1'b1;
`endif
                            end
                            default: begin
                                err_code_p1 <= ERR_BAD_CHAR;
                                err_vld_p1  <= 1'b1;
                                state       <= ST_DISCARD;
                            end
                        endcase
                    end
                    ST_DISCARD: begin
                        if (char_class == CLS_TERM) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign value       = value_p1;
    assign value_valid = vld_p1;
    assign err_code    = err_code_p1;
    assign err_valid   = err_vld_p1;
    assign digit_count = cnt;
    assign busy        = (state != ST_IDLE);

endmodule
